// File: rtl/ks_algorithm.sv
// Karplus-Strong plucked-string voice: LFSR noise fill of a circular delay line, then
// two-point averaging playback, one sample per data_over tick. Optional macro: KS_DECAY_EN.
module ks_algorithm #(
    parameter int          DATA_W      = 16,
    parameter int          LEN_W       = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          DECAY_SHIFT = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     pluck,
    input  logic                     data_over,
    input  logic [LEN_W-1:0]         stringlen,
    output logic signed [DATA_W-1:0] sample_out
);

    typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

    state_t                     state_q;
    logic [LEN_W-1:0]           cnt_q, ptr_q, len_q;
    logic [15:0]                lfsr_q;
    logic signed [DATA_W-1:0]   out_q;
    logic [2:0]                 sync_q;
    logic                       pluck_q;
    logic signed [DATA_W-1:0]   dline_q [2**LEN_W];

    logic                       tick, plk_edge;
    logic [LEN_W-1:0]           len_eff, nxt;
    logic signed [DATA_W-1:0]   cur, nb, avg, y;
    logic signed [DATA_W:0]     sum;
    logic                       we_d;
    logic [LEN_W-1:0]           waddr_d;
    logic signed [DATA_W-1:0]   wdata_d;

    // sync_q[1] is the second synchronizer stage, sync_q[2] the edge flop
    assign tick     = sync_q[1] & ~sync_q[2];
    assign plk_edge = pluck & ~pluck_q;
    assign len_eff  = (stringlen < LEN_W'(2)) ? LEN_W'(2) : stringlen;
    assign nxt      = (ptr_q == len_q - 1'b1) ? '0 : ptr_q + 1'b1;

    assign cur = dline_q[ptr_q];
    assign nb  = dline_q[nxt];
    assign sum = {cur[DATA_W-1], cur} + {nb[DATA_W-1], nb};
    assign avg = DATA_W'(sum >>> 1);
`ifdef KS_DECAY_EN
    assign y = avg - (avg >>> DECAY_SHIFT);
`else
    assign y = avg;
`endif

    // A pluck edge suppresses any delay-line write in the same cycle
    always_comb begin
        we_d    = 1'b0;
        waddr_d = cnt_q;
        wdata_d = lfsr_q[DATA_W-1:0];
        if (!plk_edge) begin
            if (state_q == FILL) begin
                we_d = 1'b1;
            end else if (state_q == PLAY && tick) begin
                we_d    = 1'b1;
                waddr_d = ptr_q;
                wdata_d = y;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (we_d) dline_q[waddr_d] <= wdata_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            len_q   <= LEN_W'(2);
            lfsr_q  <= LFSR_SEED;
            out_q   <= '0;
            sync_q  <= '0;
            pluck_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            sync_q  <= {sync_q[1:0], data_over};
            pluck_q <= pluck;
            if (plk_edge) begin
                state_q <= FILL;
                cnt_q   <= '0;
                len_q   <= len_eff;
                out_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: out_q <= '0;
                    FILL: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) begin
                            state_q <= PLAY;
                            ptr_q   <= '0;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            out_q <= cur;
                            ptr_q <= nxt;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample_out = out_q;

endmodule

// File: tb/tb_ks_algorithm.sv
// Randomized-length bench for ks_algorithm against an array-based Karplus-Strong model.
module tb_ks_algorithm;
    logic               Clk = 1'b0;
    logic               Reset, pluck, data_over;
    logic [9:0]         stringlen;
    logic signed [15:0] sample_out;

    int vecs = 0, errs = 0;
    int edges;
    int mline [1024];
    int mptr, mlen;
    bit mplay;

    ks_algorithm dut (
        .Clk(Clk), .Reset(Reset), .pluck(pluck), .data_over(data_over),
        .stringlen(stringlen), .sample_out(sample_out)
    );

    always #5 Clk = ~Clk;

    // rising edges since reset release; the DUT LFSR has stepped exactly this many times
    always @(posedge Clk or posedge Reset)
        if (Reset) edges <= 0; else edges <= edges + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] l = 16'hACE1;
        for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    task automatic model_fill(input int n0, input int len);
        logic [15:0] l;
        l = lfsr_at(n0);
        for (int k = 0; k < len; k++) begin
            mline[k] = sx16(int'(l));
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        mptr = 0; mlen = len; mplay = 1'b1;
    endtask

    task automatic model_tick(output int o);
        int nx, avg, y;
        if (!mplay) begin o = 0; return; end
        o   = mline[mptr];
        nx  = (mptr + 1) % mlen;
        avg = (o + mline[nx]) >>> 1;
`ifdef KS_DECAY_EN
        y = avg - (avg >>> 8);
`else
        y = avg;
`endif
        mline[mptr] = sx16(y);
        mptr = nx;
    endtask

    task automatic tick(input string tag);
        int exp;
        @(negedge Clk) data_over = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        model_tick(exp);
        chk(tag, int'(sample_out), exp);
        @(negedge Clk) data_over = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Pluck, then aim one tick at the last FILL edge (must be dropped) and one just after
    task automatic do_pluck(input int sl);
        int e, len, exp;
        len = (sl < 2) ? 2 : sl;
        @(negedge Clk);
        stringlen = 10'(sl);
        pluck = 1'b1;
        e = edges;
        model_fill(e + 1, len);
        repeat (len - 2) @(negedge Clk);
        data_over = 1'b1;
        @(negedge Clk) data_over = 1'b0;
        @(negedge Clk) data_over = 1'b1;
        @(posedge Clk); #1;
        chk("fill_drop", int'(sample_out), 0);
        repeat (2) @(posedge Clk); #1;
        model_tick(exp);
        chk("first_play", int'(sample_out), exp);
        @(negedge Clk) data_over = 1'b0;
        pluck = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Pluck edge lands on the same clock as a tick action
    task automatic pluck_on_tick(input int sl);
        int e, len;
        len = (sl < 2) ? 2 : sl;
        @(negedge Clk) data_over = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        pluck = 1'b1;
        stringlen = 10'(sl);
        e = edges;
        @(posedge Clk); #1;
        chk("pluck_wins", int'(sample_out), 0);
        model_fill(e + 1, len);
        @(negedge Clk) data_over = 1'b0;
        repeat (len + 4) @(negedge Clk);
        pluck = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; pluck = 1'b0; data_over = 1'b0; stringlen = 10'd147;
        mplay = 1'b0; mptr = 0; mlen = 2;
        #1 chk("reset_out", int'(sample_out), 0);
        #22 Reset = 1'b0;

        // idle: slow data_over, no pluck
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk) data_over = ~data_over;
            repeat (500) @(posedge Clk);
            #1 chk("idle_mid", int'(sample_out), 0);
            repeat (500) @(posedge Clk);
            #1 chk("idle_end", int'(sample_out), 0);
        end
        @(negedge Clk) data_over = 1'b0;
        repeat (4) @(negedge Clk);

        // 147-sample string, three full periods; stringlen changed mid-play has no effect
        do_pluck(147);
        for (int i = 1; i < 3 * 147; i++) begin
            if (i == 200) stringlen = 10'($urandom_range(2, 1023));
            tick("play147");
        end

        // degenerate lengths behave as 2
        do_pluck(0);
        for (int i = 0; i < 8; i++) tick("len0");
        do_pluck(1);
        for (int i = 0; i < 8; i++) tick("len1");

        // a few random lengths
        for (int r = 0; r < 3; r++) begin
            do_pluck(int'($urandom_range(2, 90)));
            for (int i = 0; i < 40; i++) tick("rand_len");
        end

        // retrigger coinciding with a tick
        pluck_on_tick(int'($urandom_range(20, 80)));
        for (int i = 0; i < 100; i++) tick("retrig");

        // async reset between clock edges mid-PLAY
        @(negedge Clk);
        #2 Reset = 1'b1;
        mplay = 1'b0;
        #1 chk("rst_async", int'(sample_out), 0);
        @(negedge Clk) Reset = 1'b0;
        for (int i = 0; i < 5; i++) tick("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
